i2s_receiver: RTL and testbench

I2S_RECEIVER -- requirements
Module: i2s_receiver

---
 rtl/i2s_receiver.sv | 137 +++++++++++++
 tb/tb_i2s_receiver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver.sv
// i2s_receiver: captures stereo I2S audio from an ADC into clk_sys-domain
// sample registers. bclk/adclrc/adcdat are oversampled by clk; every bclk
// rise shifts one bit, and each adclrc change closes the previous half-frame.
module i2s_receiver #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             bclk,
  input  logic             adclrc,
  input  logic             adcdat,
  output logic [WIDTH-1:0] left_data,
  output logic [WIDTH-1:0] right_data,
  output logic             sample_valid,
  output logic             frame_err,
  output logic             locked
);

  // state | meaning
  // IDLE  | receive disabled; outputs hold their last values
  // SEEK  | waiting for a right-to-left boundary to align on
  // RUN   | aligned; each full left+right pair updates the outputs

  typedef enum logic [1:0] {IDLE, SEEK, RUN} state_t;

  state_t           state;
  logic [1:0]       bclk_sync;
  logic [1:0]       lrc_sync;
  logic [1:0]       dat_sync;
  logic             bclk_prev;
  logic             rise;
  logic [WIDTH-1:0] shifter;
  logic [5:0]       bit_cnt;
  logic             last_lrc;
  logic             evt_boundary;
  logic             evt_to_left;
  logic             evt_len_ok;
  logic [WIDTH-1:0] pending_left;

  assign rise = bclk_sync[1] & ~bclk_prev;

  // Two-flop synchronizers for all codec-domain inputs, plus bclk history
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync <= '0;
      lrc_sync  <= '0;
      dat_sync  <= '0;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], bclk};
      lrc_sync  <= {lrc_sync[0], adclrc};
      dat_sync  <= {dat_sync[0], adcdat};
      bclk_prev <= bclk_sync[1];
    end
  end

  // Shift on every bclk rise and register a boundary event for the FSM.
  // The event is consumed one cycle later, when the shifter already holds
  // the completed word (LSB arrives in slot 0 because of the I2S delay).
  always_ff @(posedge clk) begin
    if (reset) begin
      shifter      <= '0;
      bit_cnt      <= '0;
      last_lrc     <= 1'b0;
      evt_boundary <= 1'b0;
      evt_to_left  <= 1'b0;
      evt_len_ok   <= 1'b0;
    end else begin
      evt_boundary <= 1'b0;
      if (rise) begin
        shifter  <= {shifter[WIDTH-2:0], dat_sync[1]};
        last_lrc <= lrc_sync[1];
        if (lrc_sync[1] != last_lrc) begin
          bit_cnt      <= 6'd1;
          evt_boundary <= 1'b1;
          evt_to_left  <= ~lrc_sync[1];
          evt_len_ok   <= (bit_cnt == 6'(WIDTH));
        end else if (bit_cnt != 6'd63) begin
          bit_cnt <= bit_cnt + 6'd1;
        end
      end
    end
  end

  // Lock/run sequencing with registered outputs and single-cycle pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pending_left <= '0;
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (!enable) begin
        state        <= IDLE;
        pending_left <= '0;
        locked       <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= SEEK;
          SEEK: begin
            // the aligning boundary itself carries no usable word
            if (evt_boundary && evt_to_left) begin
              state  <= RUN;
              locked <= 1'b1;
            end
          end
          RUN: begin
            if (evt_boundary) begin
              if (!evt_len_ok) begin
                frame_err <= 1'b1;
                state     <= SEEK;
                locked    <= 1'b0;
              end else if (!evt_to_left) begin
                pending_left <= shifter;
              end else begin
                left_data    <= pending_left;
                right_data   <= shifter;
                sample_valid <= 1'b1;
              end
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: drives an I2S stream half-frame by half-frame, predicts
// pulses and sample values from a frame-level model, and checks a table of
// directed frames followed by a run of random back-to-back frames.
module tb_i2s_receiver;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         bclk;
  logic         adclrc;
  logic         adcdat;
  logic [W-1:0] left_data;
  logic [W-1:0] right_data;
  logic         sample_valid;
  logic         frame_err;
  logic         locked;

  i2s_receiver #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bclk(bclk),
    .adclrc(adclrc), .adcdat(adcdat), .left_data(left_data),
    .right_data(right_data), .sample_valid(sample_valid),
    .frame_err(frame_err), .locked(locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int hb = 8;          // clk cycles per bclk half period
  int n_valid = 0;
  int n_err = 0;

  task automatic chk_d(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  typedef struct {
    bit           is_err;
    int           cyc;
    logic [W-1:0] l;
    logic [W-1:0] r;
  } pulse_t;

  pulse_t       exp_q[$];
  bit           m_en = 1'b0;
  bit           m_run = 1'b0;
  logic [W-1:0] m_pend = '0;
  logic [W-1:0] m_left = '0;
  logic [W-1:0] m_right = '0;
  bit           s_lrc = 1'b0;    // channel of the half in progress
  int           s_len = 0;       // bclks in the half in progress
  logic [W-1:0] s_word = '0;
  bit           prev_lsb = 1'b0;

  // Called at the slot-0 rise of a new half; pulse lands 3 clks after the
  // clk edge that first samples bclk high (rise driven at cyc -> cyc+1).
  task automatic model_boundary(input bit lrc, input int nbits, input logic [W-1:0] word);
    pulse_t p;
    if (lrc != s_lrc) begin
      if (m_en) begin
        if (!m_run) begin
          if (lrc == 1'b0) m_run = 1'b1;
        end else if (s_len != W) begin
          p.is_err = 1'b1; p.cyc = cyc + 4; p.l = m_left; p.r = m_right;
          exp_q.push_back(p);
          m_run = 1'b0;
        end else if (lrc) begin
          m_pend = s_word;
        end else begin
          m_left = m_pend;
          m_right = s_word;
          p.is_err = 1'b0; p.cyc = cyc + 4; p.l = m_left; p.r = m_right;
          exp_q.push_back(p);
        end
      end
      s_len = nbits;
    end else begin
      s_len += nbits;
    end
    s_lrc = lrc;
    s_word = word;
  endtask

  // act: 1 = one-cycle reset, 2 = enable off, 3 = enable on; each takes one clk
  task automatic do_action(input int act);
    if (act == 1) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_run = 1'b0; m_pend = '0; m_left = '0; m_right = '0;
      chk_d("rst_left", left_data, '0);
      chk_d("rst_right", right_data, '0);
      chk_i("rst_locked", int'(locked), 0);
    end else if (act == 2) begin
      enable = 1'b0;
      @(negedge clk);
      m_en = 1'b0; m_run = 1'b0; m_pend = '0;
      chk_i("endrop_locked", int'(locked), 0);
      chk_d("endrop_left", left_data, m_left);
      chk_d("endrop_right", right_data, m_right);
    end else begin
      enable = 1'b1;
      @(negedge clk);
      m_en = 1'b1;
    end
  endtask

  // One half-frame of nbits bclks; starts and ends on a clk negedge.
  task automatic send_half(input bit lrc, input logic [W-1:0] word, input int nbits,
                           input int act_slot, input int act);
    for (int i = 0; i < nbits; i++) begin
      bclk = 1'b0;
      adclrc = lrc;
      if (i == 0) adcdat = prev_lsb;
      else adcdat = word[W-i];
      if (i == act_slot) begin
        do_action(act);
        repeat (hb - 1) @(negedge clk);
      end else begin
        repeat (hb) @(negedge clk);
      end
      bclk = 1'b1;
      if (i == 0) model_boundary(lrc, nbits, word);
      repeat (hb) @(negedge clk);
    end
    prev_lsb = word[0];
  endtask

  // ---------------- pulse monitor ----------------
  initial begin
    pulse_t got;
    bit prev_sv = 1'b0;
    bit prev_fe = 1'b0;
    forever begin
      @(negedge clk);
      if (sample_valid || frame_err) begin
        chk_i("pulse_exclusive", int'(sample_valid & frame_err), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: sv=%b fe=%b at cycle %0d, none expected",
                   sample_valid, frame_err, cyc);
        end else begin
          got = exp_q.pop_front();
          chk_i("pulse_kind_err", int'(frame_err), int'(got.is_err));
          chk_i("pulse_cycle", cyc, got.cyc);
          if (!got.is_err) begin
            chk_d("pulse_left", left_data, got.l);
            chk_d("pulse_right", right_data, got.r);
          end
        end
        if (sample_valid) n_valid++;
        if (frame_err) n_err++;
      end
      if (sample_valid) chk_i("sv_one_cycle", int'(prev_sv), 0);
      if (frame_err) chk_i("fe_one_cycle", int'(prev_fe), 0);
      prev_sv = sample_valid;
      prev_fe = frame_err;
    end
  end

  // ---------------- directed frame table ----------------
  typedef struct {
    logic [W-1:0] l;
    int           l_bits;
    logic [W-1:0] r;
    int           r_bits;
    int           act;
    logic [W-1:0] exp_l;
    logic [W-1:0] exp_r;
    int           exp_locked;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl[NV];

  initial begin
    logic [31:0]  rnd;
    logic [W-1:0] rl;
    logic [W-1:0] rr;
    int           base_v;
    int           base_e;
    int           act_l;
    int           act_r;

    // partial frame, lock, first sample, sign extremes, short right half,
    // relock, enable drop/restore, reset mid right half, recovery
    tbl[0]  = '{24'hAAAAAA, 10, 24'h555555, 24, 0, 24'h000000, 24'h000000, 0};
    tbl[1]  = '{24'h123456, 24, 24'hABCDEF, 24, 0, 24'h000000, 24'h000000, 1};
    tbl[2]  = '{24'h800000, 24, 24'h7FFFFF, 24, 0, 24'h123456, 24'hABCDEF, 1};
    tbl[3]  = '{24'h000001, 24, 24'hFFFFFF, 24, 0, 24'h800000, 24'h7FFFFF, 1};
    tbl[4]  = '{24'h111111, 24, 24'h222222, 23, 0, 24'h000001, 24'hFFFFFF, 1};
    tbl[5]  = '{24'h333333, 24, 24'h444444, 24, 0, 24'h000001, 24'hFFFFFF, 0};
    tbl[6]  = '{24'h555555, 24, 24'h666666, 24, 0, 24'h000001, 24'hFFFFFF, 1};
    tbl[7]  = '{24'h777777, 24, 24'h888888, 24, 2, 24'h555555, 24'h666666, 0};
    tbl[8]  = '{24'h999999, 24, 24'hAAAAAA, 24, 3, 24'h555555, 24'h666666, 0};
    tbl[9]  = '{24'hBBBBBB, 24, 24'hCCCCCC, 24, 0, 24'h555555, 24'h666666, 1};
    tbl[10] = '{24'hDDDDDD, 24, 24'hEEEEEE, 24, 1, 24'h000000, 24'h000000, 0};
    tbl[11] = '{24'h0F0F0F, 24, 24'hF0F0F0, 24, 0, 24'h000000, 24'h000000, 1};
    tbl[12] = '{24'hC3C3C3, 24, 24'h3C3C3C, 24, 0, 24'h0F0F0F, 24'hF0F0F0, 1};

    reset = 1'b1; enable = 1'b0; bclk = 1'b0; adclrc = 1'b0; adcdat = 1'b0;
    repeat (4) @(negedge clk);
    chk_d("reset_left", left_data, '0);
    chk_d("reset_right", right_data, '0);
    chk_i("reset_sv", int'(sample_valid), 0);
    chk_i("reset_fe", int'(frame_err), 0);
    chk_i("reset_locked", int'(locked), 0);
    reset = 1'b0;
    enable = 1'b1;
    m_en = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      act_l = (tbl[v].act == 2) ? 5 : ((tbl[v].act == 3) ? 2 : -1);
      act_r = (tbl[v].act == 1) ? 5 : -1;
      send_half(1'b0, tbl[v].l, tbl[v].l_bits, act_l, tbl[v].act);
      send_half(1'b1, tbl[v].r, tbl[v].r_bits, act_r, tbl[v].act);
      chk_d($sformatf("v%0d_left", v), left_data, tbl[v].exp_l);
      chk_d($sformatf("v%0d_right", v), right_data, tbl[v].exp_r);
      chk_i($sformatf("v%0d_locked", v), int'(locked), tbl[v].exp_locked);
    end

    // back-to-back random frames at the fastest permitted bclk
    hb = 4;
    rnd = $urandom; rl = rnd[W-1:0];
    send_half(1'b0, rl, W, -1, 0);
    base_v = n_valid;
    base_e = n_err;
    for (int k = 0; k < 100; k++) begin
      rnd = $urandom; rr = rnd[W-1:0];
      send_half(1'b1, rr, W, -1, 0);
      rnd = $urandom; rl = rnd[W-1:0];
      send_half(1'b0, rl, W, -1, 0);
    end
    repeat (10) @(negedge clk);
    chk_i("random_valid_count", n_valid - base_v, 100);
    chk_i("random_err_count", n_err - base_e, 0);
    chk_i("random_locked", int'(locked), 1);
    chk_i("total_err_count", n_err, 1);
    chk_i("pending_expected_pulses", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
